// File: rtl/lmn_shift_pkg.sv
// Shared types for the lmn_shift_seq serialiser: burst sequencer states and per-lane shift modes.
package lmn_shift_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Mode encoding matches the 74194 S1:S0 pins so idle 's' drives lanes unchanged.
    localparam logic [1:0] S_HOLD  = 2'b00;
    localparam logic [1:0] S_RIGHT = 2'b01;
    localparam logic [1:0] S_LEFT  = 2'b10;
    localparam logic [1:0] S_LOAD  = 2'b11;

endpackage

// File: rtl/lmn_usr_lane.sv
// One N-bit universal shift lane (74194 style) with optional rotate and synchronous clear.
module lmn_usr_lane
    import lmn_shift_pkg::*;
#(
    parameter int N = 8
) (
    input  logic         i_clk,
    input  logic         i_rst_n,
    input  logic         i_en,
    input  logic         i_sclr,
    input  logic [1:0]   i_mode,
    input  logic         i_rot,
    input  logic         i_r,
    input  logic         i_l,
    input  logic [N-1:0] i_d,
    output logic [N-1:0] o_q
);

    logic [N-1:0] r_q;
    logic         w_feed_r;
    logic         w_feed_l;

    // Rotate recirculates the bit falling off the far end instead of the serial pin.
    assign w_feed_r = i_rot ? r_q[N-1] : i_r;
    assign w_feed_l = i_rot ? r_q[0]   : i_l;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_sclr) begin
            r_q <= '0;
        end else if (i_en) begin
            case (i_mode)
                S_RIGHT: r_q <= {r_q[N-2:0], w_feed_r};
                S_LEFT:  r_q <= {w_feed_l, r_q[N-1:1]};
                S_LOAD:  r_q <= i_d;
                default: r_q <= r_q;
            endcase
        end
    end

    assign o_q = r_q;

endmodule

// File: rtl/lmn_shift_seq.sv
// C-lane universal shift register bank with a burst sequencer that loads all lanes
// and auto-shifts them a programmed number of enabled steps, then pulses done.
module lmn_shift_seq
    import lmn_shift_pkg::*;
#(
    parameter int N  = 8,
    parameter int C  = 4,
    parameter int CW = 4
) (
    input  logic           mclk,
    input  logic           clr_n,
    input  logic           cen,
    input  logic           sclr,
    input  logic [1:0]     s,
    input  logic           rot,
    input  logic [C*N-1:0] d,
    input  logic [C-1:0]   r,
    input  logic [C-1:0]   l,
    input  logic           start,
    input  logic [CW-1:0]  cnt,
    input  logic           dir,
    output logic [C*N-1:0] q,
    output logic [C-1:0]   so_msb,
    output logic [C-1:0]   so_lsb,
    output logic           busy,
    output logic           done
);

    state_t        r_state;
    logic [CW-1:0] r_cnt;
    logic          r_dir;
    logic          r_rot;
    logic          r_busy;
    logic          r_done;

    logic [1:0]    w_lane_mode;
    logic          w_lane_rot;

    // Lanes only act in IDLE (user mode, start forcing a load) or SHIFT (latched burst controls).
    always_comb begin
        w_lane_mode = S_HOLD;
        w_lane_rot  = 1'b0;
        case (r_state)
            IDLE: begin
                w_lane_mode = start ? S_LOAD : s;
                w_lane_rot  = rot;
            end
            SHIFT: begin
                w_lane_mode = r_dir ? S_LEFT : S_RIGHT;
                w_lane_rot  = r_rot;
            end
            default: begin
                w_lane_mode = S_HOLD;
                w_lane_rot  = 1'b0;
            end
        endcase
    end

    // Burst sequencer; DONE always falls back to IDLE on the next clock regardless of cen.
    always_ff @(posedge mclk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_dir   <= 1'b0;
            r_rot   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else if (sclr) begin
            r_state <= IDLE;
            r_cnt   <= '0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_done <= 1'b0;
                    if (cen && start) begin
                        r_dir <= dir;
                        r_rot <= rot;
                        r_cnt <= cnt;
                        if (cnt == '0) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= SHIFT;
                            r_busy  <= 1'b1;
                        end
                    end
                end
                SHIFT: begin
                    if (cen) begin
                        r_cnt <= r_cnt - CW'(1);
                        if (r_cnt == CW'(1)) begin
                            r_state <= DONE;
                            r_busy  <= 1'b0;
                            r_done  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_done  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < C; gi++) begin : g_lane
        logic [N-1:0] w_q;

        lmn_usr_lane #(.N(N)) u_lane (
            .i_clk   (mclk),
            .i_rst_n (clr_n),
            .i_en    (cen),
            .i_sclr  (sclr),
            .i_mode  (w_lane_mode),
            .i_rot   (w_lane_rot),
            .i_r     (r[gi]),
            .i_l     (l[gi]),
            .i_d     (d[gi*N +: N]),
            .o_q     (w_q)
        );

        assign q[gi*N +: N] = w_q;
        assign so_msb[gi]   = w_q[N-1];
        assign so_lsb[gi]   = w_q[0];
    end

    assign busy = r_busy;
    assign done = r_done;

endmodule
